dmw_addr_trans: RTL and testbench

//  Direct-mapped-window translation stage: consumes DMW0/DMW1 and CRMD CSR outputs and maps a 32-bit VA to a PA.

---
 rtl/dmw_pkg.sv | 43 ++++
 rtl/dmw_match.sv | 35 +++
 rtl/dmw_addr_trans.sv | 155 +++++++++++++++
 tb/tb_dmw_addr_trans.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmw_pkg.sv
// Shared definitions for the direct-mapped-window address translation slice.
// Holds the CRMD and DMW field positions, the memory-access-type encodings
// and the record type carried from the translation logic into the output
// register of dmw_addr_trans.
package dmw_pkg;

    // CRMD field positions
    localparam int CRMD_PLV_LO  = 0;
    localparam int CRMD_PLV_HI  = 1;
    localparam int CRMD_DA      = 3;
    localparam int CRMD_PG      = 4;
    localparam int CRMD_DATF_LO = 5;
    localparam int CRMD_DATF_HI = 6;
    localparam int CRMD_DATM_LO = 7;
    localparam int CRMD_DATM_HI = 8;

    // DMW field positions (DMW0 and DMW1 share one layout)
    localparam int DMW_PLV0    = 0;
    localparam int DMW_PLV3    = 3;
    localparam int DMW_MAT_LO  = 4;
    localparam int DMW_MAT_HI  = 5;
    localparam int DMW_PSEG_LO = 25;
    localparam int DMW_PSEG_HI = 27;
    localparam int DMW_VSEG_LO = 29;
    localparam int DMW_VSEG_HI = 31;

    // Privilege levels that a window can grant
    localparam logic [1:0] PLV_KERNEL = 2'd0;
    localparam logic [1:0] PLV_USER   = 2'd3;

    // Memory access types
    localparam logic [1:0] MAT_SUC = 2'b00;
    localparam logic [1:0] MAT_CC  = 2'b01;

    // Translated result captured by the output register
    typedef struct packed {
        logic [31:0] pa;
        logic [1:0]  mat;
        logic        hit;
        logic        tlbReq;
    } dmw_result_t;

endpackage

// File: rtl/dmw_match.sv
// Single direct-mapped-window comparator (purely combinational).
// Ports:
//   dmw   in  32  window CSR value (PLV0, PLV3, MAT, PSEG, VSEG)
//   va    in  32  virtual address
//   plv   in  2   current privilege level from CRMD
//   match out 1   VSEG equals va[31:29] and the window admits this PLV
//   pa    out 32  {PSEG, va[28:0]}, meaningful only when match is set
//   mat   out 2   memory access type of the window
module dmw_match
    import dmw_pkg::*;
(
    input  logic [31:0] dmw,
    input  logic [31:0] va,
    input  logic [1:0]  plv,
    output logic        match,
    output logic [31:0] pa,
    output logic [1:0]  mat
);

    logic privOk;
    logic unusedDmwBits;

    // Only kernel (PLV0) and user (PLV3) can be granted by a window;
    // PLV 1 and 2 fall through to the TLB.
    assign privOk = ((plv == PLV_KERNEL) && dmw[DMW_PLV0]) ||
                    ((plv == PLV_USER)   && dmw[DMW_PLV3]);

    assign match = (va[31:29] == dmw[DMW_VSEG_HI:DMW_VSEG_LO]) && privOk;
    assign pa    = {dmw[DMW_PSEG_HI:DMW_PSEG_LO], va[28:0]};
    assign mat   = dmw[DMW_MAT_HI:DMW_MAT_LO];

    // Reserved window bits carry no meaning here.
    assign unusedDmwBits = ^{dmw[2:1], dmw[24:6], dmw[28]};

endmodule

// File: rtl/dmw_addr_trans.sv
// Direct-mapped-window translation stage between address generation and
// the cache tag stage. Translates a 32-bit VA using CRMD/DMW0/DMW1, flags
// PG-mode misses as TLB requests, and registers the result behind a
// valid/ready handshake. Intake is blocked during and shortly after a CSR
// write so that no request is translated with stale window settings.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   request handshake
//   in_va, in_is_fetch  address and fetch/data selector
//   in_tag              pass-through tag
//   csr_crmd/dmw0/dmw1  CSR values, sampled only in the accept cycle
//   csr_dmw_wr          a CSR write commits at this edge
//   flush               discard held and incoming request
//   out_valid/out_ready result handshake
//   out_pa, out_mat     translated address and memory access type
//   out_dmw_hit         PG mode, a window matched
//   out_tlb_req         PG mode, no window matched
//   out_tag             tag of the result
module dmw_addr_trans
    import dmw_pkg::*;
#(
    parameter int TAG_W     = 4,
    parameter int FENCE_CYC = 1
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_va,
    input  logic             in_is_fetch,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [31:0]      csr_crmd,
    input  logic [31:0]      csr_dmw0,
    input  logic [31:0]      csr_dmw1,
    input  logic             csr_dmw_wr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pa,
    output logic [1:0]       out_mat,
    output logic             out_dmw_hit,
    output logic             out_tlb_req,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] FENCE_LOAD = 3'(FENCE_CYC);

    logic [1:0]       plv;
    logic             daMode;
    logic             match0;
    logic             match1;
    logic [31:0]      pa0;
    logic [31:0]      pa1;
    logic [1:0]       mat0;
    logic [1:0]       mat1;
    logic             accept;
    logic             unusedCrmdBits;
    dmw_result_t      trans_d;
    dmw_result_t      res_q;
    logic             outValid_q;
    logic [TAG_W-1:0] tag_q;
    logic [2:0]       fenceCnt_q;

    assign plv = csr_crmd[CRMD_PLV_HI:CRMD_PLV_LO];

    // The illegal DA=0/PG=0 combination is handled as direct address mode.
    assign daMode = csr_crmd[CRMD_DA] || !csr_crmd[CRMD_PG];

    assign unusedCrmdBits = ^{csr_crmd[31:9], csr_crmd[2]};

    dmw_match u_win0 (
        .dmw   (csr_dmw0),
        .va    (in_va),
        .plv   (plv),
        .match (match0),
        .pa    (pa0),
        .mat   (mat0)
    );

    dmw_match u_win1 (
        .dmw   (csr_dmw1),
        .va    (in_va),
        .plv   (plv),
        .match (match1),
        .pa    (pa1),
        .mat   (mat1)
    );

    // Translation for the request currently at the input: direct address
    // mode first, then DMW0 over DMW1, otherwise hand the VA to the TLB.
    always_comb begin
        trans_d = '0;
        if (daMode) begin
            trans_d.pa  = in_va;
            trans_d.mat = in_is_fetch ? csr_crmd[CRMD_DATF_HI:CRMD_DATF_LO]
                                      : csr_crmd[CRMD_DATM_HI:CRMD_DATM_LO];
        end else if (match0) begin
            trans_d.pa  = pa0;
            trans_d.mat = mat0;
            trans_d.hit = 1'b1;
        end else if (match1) begin
            trans_d.pa  = pa1;
            trans_d.mat = mat1;
            trans_d.hit = 1'b1;
        end else begin
            trans_d.pa     = in_va;
            trans_d.mat    = MAT_SUC;
            trans_d.tlbReq = 1'b1;
        end
    end

    assign in_ready = (!outValid_q || out_ready) && !csr_dmw_wr &&
                      (fenceCnt_q == 3'd0) && !flush;
    assign accept   = in_valid && in_ready;

    // Output register and fence counter. The result only changes on an
    // accept, so it stays frozen while downstream stalls; flush drops the
    // valid flag and in_ready already keeps the flushed request out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outValid_q <= 1'b0;
            res_q      <= '0;
            tag_q      <= '0;
            fenceCnt_q <= 3'd0;
        end else begin
            if (csr_dmw_wr) begin
                fenceCnt_q <= FENCE_LOAD;
            end else if (fenceCnt_q != 3'd0) begin
                fenceCnt_q <= fenceCnt_q - 3'd1;
            end

            if (flush) begin
                outValid_q <= 1'b0;
            end else if (accept) begin
                outValid_q <= 1'b1;
            end else if (out_ready) begin
                outValid_q <= 1'b0;
            end

            if (accept) begin
                res_q <= trans_d;
                tag_q <= in_tag;
            end
        end
    end

    assign out_valid   = outValid_q;
    assign out_pa      = res_q.pa;
    assign out_mat     = res_q.mat;
    assign out_dmw_hit = res_q.hit;
    assign out_tlb_req = res_q.tlbReq;
    assign out_tag     = tag_q;

endmodule

// File: tb/tb_dmw_addr_trans.sv
module tb_dmw_addr_trans;

    localparam int TAG_W     = 4;
    localparam int FENCE_CYC = 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_va;
    logic             in_is_fetch;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      csr_crmd;
    logic [31:0]      csr_dmw0;
    logic [31:0]      csr_dmw1;
    logic             csr_dmw_wr;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pa;
    logic [1:0]       out_mat;
    logic             out_dmw_hit;
    logic             out_tlb_req;
    logic [TAG_W-1:0] out_tag;

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    dmw_addr_trans #(.TAG_W(TAG_W), .FENCE_CYC(FENCE_CYC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_va       (in_va),
        .in_is_fetch (in_is_fetch),
        .in_tag      (in_tag),
        .csr_crmd    (csr_crmd),
        .csr_dmw0    (csr_dmw0),
        .csr_dmw1    (csr_dmw1),
        .csr_dmw_wr  (csr_dmw_wr),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pa      (out_pa),
        .out_mat     (out_mat),
        .out_dmw_hit (out_dmw_hit),
        .out_tlb_req (out_tlb_req),
        .out_tag     (out_tag)
    );

    int compared   = 0;
    int mismatched = 0;

    // Transaction-level model of the stage
    logic             modelKnown = 1'b0;
    logic             expValid   = 1'b0;
    logic [35:0]      expRes     = '0;
    logic [TAG_W-1:0] expTag     = '0;
    int               cycleIdx   = 0;
    int               lastWr     = -100;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference translation {pa, mat, hit, tlb_req} from the CSR field rules.
    function automatic logic [35:0] refTranslate(input logic [31:0] crmd,
                                                 input logic [31:0] d0,
                                                 input logic [31:0] d1,
                                                 input logic [31:0] va,
                                                 input logic fetch);
        logic [31:0] win [2];
        logic [31:0] plv;
        logic [31:0] pseg;
        logic [1:0]  mat;
        logic        priv;
        plv = crmd % 4;
        if (((crmd / 8) % 2 == 1) || ((crmd / 16) % 2 == 0)) begin
            mat = fetch ? 2'((crmd / 32) % 4) : 2'((crmd / 128) % 4);
            return {va, mat, 1'b0, 1'b0};
        end
        win[0] = d0;
        win[1] = d1;
        for (int w = 0; w < 2; w++) begin
            priv = ((plv == 0) && (win[w] % 2 == 1)) ||
                   ((plv == 3) && ((win[w] / 8) % 2 == 1));
            if (priv && (win[w] / (1 << 29) == va / (1 << 29))) begin
                pseg = (win[w] / (1 << 25)) % 8;
                mat  = 2'((win[w] / 16) % 4);
                return {(pseg << 29) | (va & 32'h1FFF_FFFF), mat, 1'b1, 1'b0};
            end
        end
        return {va, 2'b00, 1'b0, 1'b1};
    endfunction

    task automatic applyStimulus(input logic v, input logic [31:0] va, input logic fetch,
                                 input logic [TAG_W-1:0] tag, input logic ordy,
                                 input logic wr, input logic fl);
        in_valid    = v;
        in_va       = va;
        in_is_fetch = fetch;
        in_tag      = tag;
        out_ready   = ordy;
        csr_dmw_wr  = wr;
        flush       = fl;
    endtask

    // One clock: check in_ready mid-cycle, advance the model, check outputs after the edge.
    task automatic stepCycle();
        logic expReady;
        logic accept;
        @(negedge clk);
        if (csr_dmw_wr) lastWr = cycleIdx;
        expReady = (!expValid || out_ready) && ((cycleIdx - lastWr) > FENCE_CYC) && !flush;
        if (modelKnown) checkOutput("in_ready", 64'(in_ready), 64'(expReady));
        accept = in_valid && expReady;
        if (!rst_n) begin
            expValid   = 1'b0;
            expRes     = '0;
            expTag     = '0;
            lastWr     = -100;
            modelKnown = 1'b1;
        end else if (modelKnown) begin
            if (accept) begin
                expRes = refTranslate(csr_crmd, csr_dmw0, csr_dmw1, in_va, in_is_fetch);
                expTag = in_tag;
            end
            if (flush) expValid = 1'b0;
            else if (accept) expValid = 1'b1;
            else if (out_ready) expValid = 1'b0;
        end
        @(posedge clk);
        #1;
        cycleIdx++;
        if (modelKnown) begin
            checkOutput("out_valid", 64'(out_valid), 64'(expValid));
            checkOutput("out_data", 64'({out_pa, out_mat, out_dmw_hit, out_tlb_req, out_tag}),
                        64'({expRes, expTag}));
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rva;
        rst_n    = 1'b0;
        csr_crmd = 32'h0;
        csr_dmw0 = 32'h0;
        csr_dmw1 = 32'h0;
        applyStimulus(1'b0, 32'h0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        stepCycle();
        stepCycle();
        rst_n = 1'b1;
        checkOutput("rst_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_pa", 64'(out_pa), 64'd0);

        // Direct address mode, data then fetch
        csr_crmd = 32'h0000_0188;
        applyStimulus(1'b1, 32'h1234_5678, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0);
        stepCycle();
        checkOutput("da_data_pa", 64'(out_pa), 64'h1234_5678);
        checkOutput("da_data_mat", 64'(out_mat), 64'd3);
        applyStimulus(1'b1, 32'h1234_5678, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0);
        stepCycle();
        checkOutput("da_fetch_mat", 64'(out_mat), 64'd0);

        // PG window hit at PLV0, miss at PLV3
        csr_crmd = 32'h10;
        csr_dmw0 = 32'hA000_0011;
        csr_dmw1 = 32'h0;
        applyStimulus(1'b1, 32'hA000_1000, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0);
        stepCycle();
        checkOutput("pg_hit_pa", 64'(out_pa), 64'h0000_1000);
        checkOutput("pg_hit_mat", 64'(out_mat), 64'd1);
        checkOutput("pg_hit_flag", 64'(out_dmw_hit), 64'd1);
        csr_crmd = 32'h13;
        stepCycle();
        checkOutput("pg_miss_tlb", 64'(out_tlb_req), 64'd1);
        checkOutput("pg_miss_pa", 64'(out_pa), 64'hA000_1000);

        // Both windows match, DMW0 wins
        csr_crmd = 32'h10;
        csr_dmw0 = 32'h8000_0001;
        csr_dmw1 = 32'h8200_0011;
        applyStimulus(1'b1, 32'h8000_0040, 1'b0, 4'h4, 1'b1, 1'b0, 1'b0);
        stepCycle();
        checkOutput("prio_pa", 64'(out_pa), 64'h0000_0040);
        checkOutput("prio_mat", 64'(out_mat), 64'd0);

        // Backpressure: three stalled cycles, then drain and accept together
        applyStimulus(1'b1, 32'h8000_0080, 1'b0, 4'h5, 1'b1, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 32'h1111_1111, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) stepCycle();
        checkOutput("stall_ready", 64'(in_ready), 64'd0);
        checkOutput("stall_tag", 64'(out_tag), 64'h5);
        out_ready = 1'b1;
        stepCycle();
        checkOutput("drain_tag", 64'(out_tag), 64'h6);

        // Fence after a CSR write; the new DMW0 is used once intake reopens
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        #1;
        checkOutput("fence_t0", 64'(in_ready), 64'd0);
        stepCycle();
        csr_dmw0 = 32'hA200_0011;
        applyStimulus(1'b1, 32'hA000_0100, 1'b0, 4'h7, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("fence_t1", 64'(in_ready), 64'd0);
        stepCycle();
        checkOutput("fence_t2", 64'(in_ready), 64'd1);
        stepCycle();
        checkOutput("fence_pa", 64'(out_pa), 64'h2000_0100);

        // Flush with a held result and a pending request
        applyStimulus(1'b1, 32'hA000_0200, 1'b0, 4'h8, 1'b0, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 32'hA000_0300, 1'b0, 4'h9, 1'b0, 1'b0, 1'b1);
        stepCycle();
        checkOutput("flush_valid", 64'(out_valid), 64'd0);
        applyStimulus(1'b1, 32'hA000_0400, 1'b0, 4'hA, 1'b1, 1'b0, 1'b0);
        stepCycle();
        rst_n = 1'b0;
        stepCycle();
        checkOutput("midrst_out", 64'({out_valid, out_pa, out_mat, out_dmw_hit, out_tlb_req, out_tag}),
                    64'd0);
        rst_n = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic wr;
            wr = ($urandom_range(0, 9) == 0);
            if (wr) begin
                csr_crmd = $urandom & 32'h1FF;
                if ($urandom_range(0, 1) == 1) csr_crmd = (csr_crmd & ~32'h8) | 32'h10;
                csr_dmw0 = {3'($urandom_range(4, 5)), 29'($urandom)};
                csr_dmw1 = {3'($urandom_range(4, 5)), 29'($urandom)};
            end
            rva = {3'($urandom_range(4, 5)), 29'($urandom)};
            applyStimulus($urandom_range(0, 3) != 0, rva, 1'($urandom), 4'($urandom),
                          $urandom_range(0, 9) < 7, wr, $urandom_range(0, 31) == 0);
            rst_n = ($urandom_range(0, 99) != 0);
            stepCycle();
            rst_n = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
